// File: rtl/pc_sequencer.sv
// Control-flow sequencer: turns flow ops plus stall into program-counter commands and owns a return-address stack.
// Latency: commands are combinational (the counter registers them, giving 1 cycle flow-op to new cur_addr); stack/state are registered.
// Backpressure: stall freezes the counter at cur_addr with no stack effect; FAULT halts the counter until RST.
//
// Ports:
//   CLK, RST          - single clock, synchronous active-high reset
//   flow_op           - 0 NOP, 1 JMP, 2 CALL, 3 RET (for the instruction at cur_addr)
//   target, cur_addr  - JMP/CALL destination and the counter's current address
//   stall             - hold the counter at cur_addr this cycle
//   jump_code         - 0 RESET, 1 JUMP, 2 RET, 3 DEFAULT (increment)
//   jump_address      - jump destination (0 when jump_code is 2 or 3)
//   return_address    - top of the return stack
//   stack_count       - number of valid stack entries
//   fault             - high while in FAULT
//
// Optional feature: define PC_SEQ_STACK_GUARD_EN to turn stack overflow/underflow
// into a sticky FAULT. Without it the stack wraps (overwrite oldest / stale pop).

module pc_sequencer #(
    parameter int INSTR_ADDR_SIZE = 8,
    parameter int STACK_DEPTH     = 4,
    parameter int RESET_CYCLES    = 2
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [1:0]                       flow_op,
    input  logic [INSTR_ADDR_SIZE-1:0]       target,
    input  logic [INSTR_ADDR_SIZE-1:0]       cur_addr,
    input  logic                             stall,
    output logic [1:0]                       jump_code,
    output logic [INSTR_ADDR_SIZE-1:0]       jump_address,
    output logic [INSTR_ADDR_SIZE-1:0]       return_address,
    output logic [$clog2(STACK_DEPTH):0]     stack_count,
    output logic                             fault
);

    localparam int AW    = INSTR_ADDR_SIZE;
    localparam int PW    = $clog2(STACK_DEPTH);
    localparam int CNT_W = PW + 1;
    localparam int CW    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(STACK_DEPTH);
    localparam logic [CW-1:0]    INIT_LAST = CW'(RESET_CYCLES - 1);

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_JMP  = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    localparam logic [1:0] CODE_RESET   = 2'd0;
    localparam logic [1:0] CODE_JUMP    = 2'd1;
    localparam logic [1:0] CODE_RET     = 2'd2;
    localparam logic [1:0] CODE_DEFAULT = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    init_cnt_q, init_cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AW-1:0]    stack_q [STACK_DEPTH];
    logic [AW-1:0]    stack_d [STACK_DEPTH];

`ifdef PC_SEQ_STACK_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
    assign fault = (state_q == ST_FAULT);
`else
    localparam bit GUARD_EN = 1'b0;
    assign fault = 1'b0;
`endif

    // Top of stack is read straight out of the entry flops, so it is already
    // valid in the cycle a RET is presented (a CALL->RET pair needs no bubble).
    assign return_address = stack_q[ptr_q - PW'(1)];
    assign stack_count    = count_q;

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        ptr_d        = ptr_q;
        count_d      = count_q;
        stack_d      = stack_q;
        jump_code    = CODE_RESET;
        jump_address = '0;

        if (!RST) begin
            unique case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_d    = ST_RUN;
                        init_cnt_d = '0;
                    end else begin
                        init_cnt_d = init_cnt_q + CW'(1);
                    end
                end

                ST_RUN: begin
                    if (stall) begin
                        jump_code    = CODE_JUMP;
                        jump_address = cur_addr;
                    end else begin
                        unique case (flow_op)
                            OP_NOP: begin
                                jump_code = CODE_DEFAULT;
                            end
                            OP_JMP: begin
                                jump_code    = CODE_JUMP;
                                jump_address = target;
                            end
                            OP_CALL: begin
                                if (GUARD_EN && (count_q == DEPTH_CNT)) begin
                                    // Overflow: show the halt command now, fault at the edge.
                                    jump_code    = CODE_JUMP;
                                    jump_address = cur_addr;
                                    state_d      = ST_FAULT;
                                end else begin
                                    jump_code      = CODE_JUMP;
                                    jump_address   = target;
                                    stack_d[ptr_q] = cur_addr + AW'(1);
                                    ptr_d          = ptr_q + PW'(1);
                                    // Unguarded full stack: oldest entry is overwritten, count saturates.
                                    count_d = (count_q == DEPTH_CNT) ? count_q : count_q + CNT_W'(1);
                                end
                            end
                            OP_RET: begin
                                if (GUARD_EN && (count_q == '0)) begin
                                    jump_code    = CODE_JUMP;
                                    jump_address = cur_addr;
                                    state_d      = ST_FAULT;
                                end else begin
                                    jump_code = CODE_RET;
                                    ptr_d     = ptr_q - PW'(1);
                                    // Unguarded empty stack: pointer still moves, count stays 0.
                                    count_d = (count_q == '0) ? count_q : count_q - CNT_W'(1);
                                end
                            end
                            default: begin
                                jump_code = CODE_DEFAULT;
                            end
                        endcase
                    end
                end

                ST_FAULT: begin
                    jump_code    = CODE_JUMP;
                    jump_address = cur_addr;
                end

                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a behavioural model of the stack,
// reset window and program counter.
// Directed test-plan steps followed by a randomized phase.

module tb_pc_sequencer;

    localparam int AW = 8;
    localparam int D  = 4;
    localparam int N  = 2;

`ifdef PC_SEQ_STACK_GUARD_EN
    localparam bit G = 1'b1;
`else
    localparam bit G = 1'b0;
`endif

    logic          CLK;
    logic          RST;
    logic [1:0]    flow_op;
    logic [AW-1:0] target;
    logic [AW-1:0] cur_addr;
    logic          stall;
    logic [1:0]    jump_code;
    logic [AW-1:0] jump_address;
    logic [AW-1:0] return_address;
    logic [2:0]    stack_count;
    logic          fault;

    pc_sequencer #(
        .INSTR_ADDR_SIZE (AW),
        .STACK_DEPTH     (D),
        .RESET_CYCLES    (N)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .flow_op        (flow_op),
        .target         (target),
        .cur_addr       (cur_addr),
        .stall          (stall),
        .jump_code      (jump_code),
        .jump_address   (jump_address),
        .return_address (return_address),
        .stack_count    (stack_count),
        .fault          (fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: circular stack, reset window, sticky fault, program counter.
    int m_mem [D];
    int m_ptr;
    int m_cnt;
    int m_zero_left;
    bit m_faulted;
    int m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) m_mem[i] = 0;
        m_ptr       = 0;
        m_cnt       = 0;
        m_faulted   = 1'b0;
        m_zero_left = N;
    endtask

    // One cycle: drive inputs after the edge, check outputs, advance the model to the next edge.
    task automatic step(input int op, input int tgt, input bit stl, input bit rst);
        int  ecode;
        int  eaddr;
        int  top;
        bit  in_init;
        @(posedge CLK);
        #1;
        RST      = rst;
        flow_op  = op[1:0];
        target   = tgt[AW-1:0];
        stall    = stl;
        cur_addr = m_pc[AW-1:0];
        #1;
        top     = m_mem[(m_ptr + D - 1) % D];
        in_init = rst || (m_zero_left > 0);
        ecode   = 0;
        eaddr   = 0;
        if (in_init) begin
            ecode = 0;
        end else if (m_faulted) begin
            ecode = 1; eaddr = m_pc;
        end else if (stl) begin
            ecode = 1; eaddr = m_pc;
        end else begin
            case (op)
                0: ecode = 3;
                1: begin ecode = 1; eaddr = tgt; end
                2: begin
                    ecode = 1;
                    eaddr = (G && m_cnt == D) ? m_pc : tgt;
                end
                default: begin
                    if (G && m_cnt == 0) begin ecode = 1; eaddr = m_pc; end
                    else ecode = 2;
                end
            endcase
        end

        chk("jump_code",      {30'd0, jump_code},        ecode);
        chk("jump_address",   {24'd0, jump_address},     eaddr);
        chk("return_address", {24'd0, return_address},   top);
        chk("stack_count",    {29'd0, stack_count},      m_cnt);
        chk("fault",          {31'd0, fault},            {31'd0, m_faulted});

        // Counter update (uses the model's command, not the DUT's).
        case (ecode)
            0: m_pc = 0;
            1: m_pc = eaddr;
            2: m_pc = top;
            default: m_pc = (m_pc + 1) % 256;
        endcase

        // Sequencer state update at the edge.
        if (rst) begin
            model_clear();
        end else if (m_zero_left > 0) begin
            m_zero_left--;
        end else if (!m_faulted && !stl) begin
            if (op == 2) begin
                if (G && m_cnt == D) m_faulted = 1'b1;
                else begin
                    m_mem[m_ptr] = (cur_addr + 1) % 256;
                    m_ptr = (m_ptr + 1) % D;
                    m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
                end
            end else if (op == 3) begin
                if (G && m_cnt == 0) m_faulted = 1'b1;
                else begin
                    m_ptr = (m_ptr + D - 1) % D;
                    m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
                end
            end
        end
    endtask

    initial begin
        RST      = 1'b1;
        flow_op  = 2'd0;
        target   = '0;
        cur_addr = '0;
        stall    = 1'b0;
        model_clear();
        m_pc = 0;

        // Reset sequence: RST held 3 cycles, then NOPs (0, 0, then 3).
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Nested call/return from 0x10.
        step(1, 'h10, 0, 0);
        step(2, 'h40, 0, 0);
        step(2, 'h80, 0, 0);
        step(3, 0, 0, 0);
        step(3, 0, 0, 0);
        step(0, 0, 0, 0);

        // Stall priority over CALL at 0x05, then the CALL executes.
        step(1, 'h05, 0, 0);
        step(2, 'h20, 1, 0);
        step(2, 'h20, 0, 0);
        step(3, 0, 0, 0);
        step(0, 0, 0, 0);

        // Address wrap: CALL at 0xFF pushes 0x00; RET immediately after.
        step(1, 'hFF, 0, 0);
        step(2, 'h30, 0, 0);
        step(3, 0, 0, 0);
        step(0, 0, 0, 0);

        // Five CALLs on a 4-deep stack, then five RETs (last one on empty).
        for (int i = 0; i < 5; i++) step(2, 'h60 + 16 * i, 0, 0);
        for (int i = 0; i < 5; i++) step(3, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Recover through reset.
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // RST in the middle of a CALL and of a RET.
        step(2, 'h22, 0, 0);
        step(2, 'h33, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(2, 'h44, 0, 0);
        step(3, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3), $urandom_range(0, 255),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
